// File: rtl/byte_deser.sv
// Byte deserializer: gathers din_bytecount+1 bytes, LSB first, into a 256-bit word
// and offers it on a valid/ready port. Optional idle timeout: BYTE_DESER_TIMEOUT_EN.
module byte_deser #(
   parameter int unsigned WIDTH_BYTES    = 32,
   parameter int unsigned TIMEOUT_CYCLES = 256
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       start,
   input  logic [4:0]                 din_bytecount,
   input  logic [7:0]                 din,
   input  logic                       din_valid,
   output logic [8*WIDTH_BYTES-1:0]   dout,
   output logic                       dout_valid,
   input  logic                       dout_ready,
   output logic                       busy,
   output logic                       empty,
   output logic                       err
);

   localparam int unsigned DOUT_W = 8 * WIDTH_BYTES;
   localparam int unsigned IDX_W  = 6;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RECV = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // The 5-bit count and byte addressing assume exactly 32 bytes per word.
   if (WIDTH_BYTES != 32) begin : g_bad_width
      $error("byte_deser: WIDTH_BYTES must be 32");
   end
   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("byte_deser: TIMEOUT_CYCLES must be at least 1");
   end

   state_t               r_state;
   logic [DOUT_W-1:0]    r_data;
   logic [IDX_W-1:0]     r_idx;
   logic [IDX_W-1:0]     r_target;
   logic                 r_dout_valid;
   logic                 r_busy;
   logic                 r_empty;
   logic                 r_err;
   logic [7:0]           w_bit_base;
   logic                 w_last_byte;

`ifdef BYTE_DESER_TIMEOUT_EN
   localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   logic [CNT_W-1:0]     r_idle_cnt;
   logic                 w_timeout;

   // Abort on the idle cycle that would bring the count up to TIMEOUT_CYCLES.
   assign w_timeout = (r_idle_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`endif

   assign w_bit_base  = {r_idx[4:0], 3'b000};
   assign w_last_byte = (r_idx == (r_target - 6'd1));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state      <= ST_IDLE;
         r_data       <= '0;
         r_idx        <= '0;
         r_target     <= '0;
         r_dout_valid <= 1'b0;
         r_busy       <= 1'b0;
         r_empty      <= 1'b1;
         r_err        <= 1'b0;
`ifdef BYTE_DESER_TIMEOUT_EN
         r_idle_cnt   <= '0;
`endif
      end else begin
         r_err <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               // A byte seen in IDLE is dropped, even alongside start.
               if (din_valid) begin
                  r_err <= 1'b1;
               end
               if (start) begin
                  r_target <= 6'(din_bytecount) + 6'd1;
                  r_data   <= '0;
                  r_idx    <= '0;
                  r_state  <= ST_RECV;
                  r_busy   <= 1'b1;
                  r_empty  <= 1'b0;
`ifdef BYTE_DESER_TIMEOUT_EN
                  r_idle_cnt <= '0;
`endif
               end
            end

            ST_RECV: begin
               if (din_valid) begin
                  r_data[w_bit_base +: 8] <= din;
                  r_idx                   <= r_idx + 6'd1;
`ifdef BYTE_DESER_TIMEOUT_EN
                  r_idle_cnt              <= '0;
`endif
                  if (w_last_byte) begin
                     r_state      <= ST_DONE;
                     r_dout_valid <= 1'b1;
                  end
               end
`ifdef BYTE_DESER_TIMEOUT_EN
               else if (w_timeout) begin
                  r_state    <= ST_IDLE;
                  r_data     <= '0;
                  r_idx      <= '0;
                  r_busy     <= 1'b0;
                  r_empty    <= 1'b1;
                  r_err      <= 1'b1;
                  r_idle_cnt <= '0;
               end else begin
                  r_idle_cnt <= r_idle_cnt + CNT_W'(1);
               end
`endif
            end

            ST_DONE: begin
               if (din_valid) begin
                  r_err <= 1'b1;
               end
               // start is ignored here; the word stays put after release.
               if (dout_ready) begin
                  r_state      <= ST_IDLE;
                  r_dout_valid <= 1'b0;
                  r_busy       <= 1'b0;
                  r_empty      <= 1'b1;
               end
            end

            default: begin
               r_state      <= ST_IDLE;
               r_dout_valid <= 1'b0;
               r_busy       <= 1'b0;
               r_empty      <= 1'b1;
            end
         endcase
      end
   end

   assign dout       = r_data;
   assign dout_valid = r_dout_valid;
   assign busy       = r_busy;
   assign empty      = r_empty;
   assign err        = r_err;

endmodule

// File: tb/tb_byte_deser.sv
// Self-checking bench for byte_deser: directed cases plus randomized frames,
// expected words built arithmetically from the bytes the bench sends.
module tb_byte_deser;

   logic         clk;
   logic         rst_n;
   logic         start;
   logic [4:0]   din_bytecount;
   logic [7:0]   din;
   logic         din_valid;
   logic [255:0] dout;
   logic         dout_valid;
   logic         dout_ready;
   logic         busy;
   logic         empty;
   logic         err;

   int n_tests = 0;
   int n_fail  = 0;

   byte_deser #(
      .WIDTH_BYTES    (32),
      .TIMEOUT_CYCLES (4)
   ) u_dut (
      .clk           (clk),
      .reset         (rst_n),
      .start         (start),
      .din_bytecount (din_bytecount),
      .din           (din),
      .din_valid     (din_valid),
      .dout          (dout),
      .dout_valid    (dout_valid),
      .dout_ready    (dout_ready),
      .busy          (busy),
      .empty         (empty),
      .err           (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // mode: 0 random bytes, 1 bytes 0..n-1, 2 bytes 0x11*(i+1) with gaps, 3 byte 0xA5
   task automatic do_frame(input int n, input int mode, input bit drop_on_start,
                           input int hold, input bit poke);
      logic [255:0] exp;
      logic [7:0]   b;
      int           gaps;
      bit           pk;
      exp = '0;
      start = 1'b1; din_bytecount = 5'(n - 1); din_valid = drop_on_start; din = 8'hEE;
      tick();
      start = 1'b0; din_valid = 1'b0;
      chk("start_busy", busy, 1);
      chk("start_empty", empty, 0);
      chk("start_err", err, drop_on_start);
      chk("start_dv", dout_valid, 0);
      for (int i = 0; i < n; i++) begin
         case (mode)
            0:       gaps = $urandom_range(3);
            2:       gaps = 1 + $urandom_range(2);
            default: gaps = 0;
         endcase
         for (int g = 0; g < gaps; g++) begin
            din_valid = 1'b0;
            start = 1'($urandom_range(1));
            tick();
            chk("gap_dv", dout_valid, 0);
            chk("gap_err", err, 0);
            chk("gap_busy", busy, 1);
         end
         start = 1'b0;
         case (mode)
            1:       b = 8'(i);
            2:       b = 8'(32'h11 * (i + 1));
            3:       b = 8'hA5;
            default: b = 8'($urandom);
         endcase
         din = b; din_valid = 1'b1;
         exp = exp | (256'(b) << (8 * i));
         tick();
         din_valid = 1'b0;
         if (i < n - 1) chk("recv_dv", dout_valid, 0);
         chk("recv_err", err, 0);
      end
      chk("done_dv", dout_valid, 1);
      chk("done_dout", dout, exp);
      chk("done_busy", busy, 1);
      chk("done_empty", empty, 0);
      for (int h = 0; h < hold; h++) begin
         pk = poke && (h == hold / 2);
         din_valid = pk; din = 8'($urandom);
         start = 1'($urandom_range(1));
         tick();
         din_valid = 1'b0; start = 1'b0;
         chk("hold_err", err, pk);
         chk("hold_dv", dout_valid, 1);
         chk("hold_dout", dout, exp);
      end
      dout_ready = 1'b1;
      start = 1'($urandom_range(1));
      tick();
      dout_ready = 1'b0; start = 1'b0;
      chk("rel_dv", dout_valid, 0);
      chk("rel_empty", empty, 1);
      chk("rel_busy", busy, 0);
      chk("rel_dout", dout, exp);
      chk("rel_err", err, 0);
      tick();
      chk("idle_empty", empty, 1);
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; din_bytecount = '0; din = '0;
      din_valid = 1'b0; dout_ready = 1'b0;
      tick();
      tick();
      chk("rst_dout", dout, 0);
      chk("rst_dv", dout_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_empty", empty, 1);
      chk("rst_err", err, 0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // Single byte
      do_frame(1, 3, 1'b0, 0, 1'b0);
      // Full frame, back to back
      do_frame(32, 1, 1'b0, 0, 1'b0);
      // Gapped input with 5 cycles of backpressure and a stray byte
      do_frame(4, 2, 1'b0, 5, 1'b1);
      // start together with din_valid in IDLE
      do_frame(3, 0, 1'b1, 1, 1'b0);

      // Stray byte in IDLE
      din_valid = 1'b1; din = 8'h5A;
      tick();
      din_valid = 1'b0;
      chk("idle_drop_err", err, 1);
      chk("idle_drop_empty", empty, 1);
      tick();
      chk("idle_drop_err_clr", err, 0);

      // Reset mid-frame, checked before any clock edge
      start = 1'b1; din_bytecount = 5'd7;
      tick();
      start = 1'b0;
      din_valid = 1'b1; din = 8'h12;
      tick();
      din = 8'h34;
      tick();
      din_valid = 1'b0;
      #1 rst_n = 1'b0;
      #1;
      chk("mid_rst_empty", empty, 1);
      chk("mid_rst_dout", dout, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_dv", dout_valid, 0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      do_frame(1, 0, 1'b0, 1, 1'b0);

      // Idle gap of 4 cycles after 2 of 4 bytes
      start = 1'b1; din_bytecount = 5'd3;
      tick();
      start = 1'b0;
      din_valid = 1'b1; din = 8'hC1;
      tick();
      din = 8'hC2;
      tick();
      din_valid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("to_wait_err", err, 0);
         chk("to_wait_busy", busy, 1);
      end
      tick();
`ifdef BYTE_DESER_TIMEOUT_EN
      chk("to_err", err, 1);
      chk("to_empty", empty, 1);
      chk("to_dv", dout_valid, 0);
      tick();
      chk("to_err_clr", err, 0);
      chk("to_dv_after", dout_valid, 0);
`else
      chk("to_none_err", err, 0);
      chk("to_none_busy", busy, 1);
      din_valid = 1'b1; din = 8'hC3;
      tick();
      din = 8'hC4;
      tick();
      din_valid = 1'b0;
      chk("to_none_dv", dout_valid, 1);
      chk("to_none_dout", dout, 256'hC4C3C2C1);
      dout_ready = 1'b1;
      tick();
      dout_ready = 1'b0;
      chk("to_none_rel", empty, 1);
`endif

      // Randomized frames
      for (int f = 0; f < 25; f++) begin
         do_frame(1 + $urandom_range(31), 0, 1'($urandom_range(1)),
                  $urandom_range(4), 1'($urandom_range(1)));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
